chacha_block_core: RTL

Iterative ChaCha block function that turns a key, a nonce and a block counter into one 512-bit keystream block. It feeds the team's combinational chacha_qr quarter-round block: four instances run in parallel, and each clock cycle applies one column round or one diagonal round. Its upstream is the key/nonce/counter controller and its downstream is the keystream XOR stage. Both sides use valid/ready handshakes.

---
 rtl/chacha_pkg.sv | 20 ++
 rtl/chacha_qr.sv | 30 +++
 rtl/chacha_block_core.sv | 127 ++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: the sigma constants, the state shape, the round index tables
// and the FSM state encoding.
package chacha_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;

    localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

    typedef logic [WORD_W-1:0]                 word_t;
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0]  state_t;

    // Each row lists the state words fed to one quarter-round, in (a,b,c,d) order
    localparam int COL_IDX  [4][4] = '{'{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}};
    localparam int DIAG_IDX [4][4] = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}};

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUTPUT} state_e;
endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] c_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] a_o,
    output logic [WORD_W-1:0] b_o,
    output logic [WORD_W-1:0] c_o,
    output logic [WORD_W-1:0] d_o
);
    word_t a1, b1, c1, d1, b2, d2;

    always_comb begin
        a1  = a_i + b_i;
        d1  = d_i ^ a1;
        d1  = {d1[15:0], d1[31:16]};
        c1  = c_i + d1;
        b1  = b_i ^ c1;
        b1  = {b1[19:0], b1[31:20]};
        a_o = a1 + b1;
        d2  = d1 ^ a_o;
        d_o = {d2[23:0], d2[31:24]};
        c_o = c1 + d_o;
        b2  = b1 ^ c_o;
        b_o = {b2[24:0], b2[31:25]};
    end
endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per cycle through four
// parallel quarter-rounds, then the feed-forward add into a registered keystream.
module chacha_block_core
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream
);
    localparam int RW = $clog2(ROUNDS);

    generate
        if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_rounds_check
            $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [RW-1:0]   round_q, round_d;
    state_t          work_q, work_d, init_q, init_d, ks_q, ks_d;
    logic            out_valid_q, out_valid_d;
    state_t          load_state, round_result;
    word_t           qr_in  [4][4];
    word_t           qr_out [4][4];

    always_comb begin
        load_state     = '0;
        load_state[0]  = SIGMA0;
        load_state[1]  = SIGMA1;
        load_state[2]  = SIGMA2;
        load_state[3]  = SIGMA3;
        for (int i = 0; i < 8; i++) load_state[4+i] = key[32*i +: 32];
        load_state[12] = counter;
        for (int i = 0; i < 3; i++) load_state[13+i] = nonce[32*i +: 32];
    end

    // Even rounds gather columns, odd rounds gather diagonals; results scatter back in place
    always_comb begin
        round_result = work_q;
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                qr_in[g][k] = round_q[0] ? work_q[DIAG_IDX[g][k]] : work_q[COL_IDX[g][k]];
            end
        end
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                if (round_q[0]) round_result[DIAG_IDX[g][k]] = qr_out[g][k];
                else            round_result[COL_IDX[g][k]]  = qr_out[g][k];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_qr u_qr (
            .a_i(qr_in[g][0]),  .b_i(qr_in[g][1]),  .c_i(qr_in[g][2]),  .d_i(qr_in[g][3]),
            .a_o(qr_out[g][0]), .b_o(qr_out[g][1]), .c_o(qr_out[g][2]), .d_o(qr_out[g][3])
        );
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        work_d      = work_q;
        init_d      = init_q;
        ks_d        = ks_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = load_state;
                    init_d  = load_state;
                    round_d = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                work_d  = round_result;
                round_d = round_q + 1'b1;
                if (round_q == RW'(ROUNDS - 1)) state_d = FINAL;
            end
            FINAL: begin
                for (int j = 0; j < NUM_WORDS; j++) ks_d[j] = work_q[j] + init_q[j];
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                // Keystream is left as-is after handoff; only the valid flag drops
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            work_q      <= '0;
            init_q      <= '0;
            ks_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            work_q      <= work_d;
            init_q      <= init_d;
            ks_q        <= ks_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign keystream = ks_q;
endmodule
